// File: rtl/atm_session_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : atm_session_engine                                              |
// | Brief    : Multi-operation ATM session controller with on-chip account     |
// |            store, PIN lockout, idle timeout and per-session withdraw cap.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module atm_session_engine #(
    parameter int               NUM_ACCTS   = 16,
    parameter int               BAL_W       = 32,
    parameter int               PIN_W       = 16,
    parameter int               MAX_TRIES   = 3,
    parameter int               TIMEOUT_CYC = 1024,
    parameter logic [BAL_W-1:0] WD_LIMIT    = 50000,
    parameter logic [BAL_W-1:0] INIT_BAL    = '0,
    parameter logic [PIN_W-1:0] INIT_PIN    = '0,
    localparam int              AW          = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             login_valid,
    output logic             login_ready,
    input  logic [AW-1:0]    acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_idx,
    input  logic [BAL_W-1:0] cfg_bal,
    input  logic [PIN_W-1:0] cfg_pin,
    output logic             resp_valid,
    output logic [2:0]       resp_code,
    output logic [BAL_W-1:0] balance,
    output logic [2:0]       state
);

    localparam int c_FW = $clog2(MAX_TRIES + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_FW-1:0] c_MAX_TRIES = c_FW'(MAX_TRIES);
    localparam logic [c_TW-1:0] c_TIMEOUT   = c_TW'(TIMEOUT_CYC);
    localparam logic [AW:0]     c_NUM_ACCTS = (AW+1)'(NUM_ACCTS);

    localparam logic [2:0] c_S_WAIT = 3'd0;
    localparam logic [2:0] c_S_AUTH = 3'd1;
    localparam logic [2:0] c_S_MENU = 3'd2;
    localparam logic [2:0] c_S_EXEC = 3'd3;
    localparam logic [2:0] c_S_RESP = 3'd4;

    localparam logic [2:0] c_OP_BAL    = 3'd0;
    localparam logic [2:0] c_OP_WD     = 3'd1;
    localparam logic [2:0] c_OP_DEP    = 3'd2;
    localparam logic [2:0] c_OP_CHGPIN = 3'd3;
    localparam logic [2:0] c_OP_LOGOUT = 3'd4;

    localparam logic [2:0] c_R_OK      = 3'd0;
    localparam logic [2:0] c_R_BAD_PIN = 3'd1;
    localparam logic [2:0] c_R_LOCKED  = 3'd2;
    localparam logic [2:0] c_R_NO_ACCT = 3'd3;
    localparam logic [2:0] c_R_INSUFF  = 3'd4;
    localparam logic [2:0] c_R_OVF     = 3'd5;
    localparam logic [2:0] c_R_LIMIT   = 3'd6;
    localparam logic [2:0] c_R_TIMEOUT = 3'd7;

    logic [BAL_W-1:0]     r_bal   [NUM_ACCTS];
    logic [PIN_W-1:0]     r_pin   [NUM_ACCTS];
    logic [c_FW-1:0]      r_fails [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] r_lock;

    logic [2:0]       r_state, w_state_nxt;
    logic [AW-1:0]    r_acc;
    logic             r_acc_ok, r_snap_match, r_snap_lock;
    logic [c_FW-1:0]  r_snap_fails;
    logic [2:0]       r_op;
    logic [BAL_W-1:0] r_amt, r_total, r_balance;
    logic [PIN_W-1:0] r_new_pin;
    logic [2:0]       r_resp_code;
    logic             r_to_menu;
    logic [c_TW-1:0]  r_timer;

    logic             w_login_hs, w_op_hs, w_timeout, w_login_acc_ok, w_cfg_acc_ok;
    logic [2:0]       w_auth_code, w_ex_code;
    logic [c_FW-1:0]  w_fail_inc;
    logic [BAL_W-1:0] w_cur_bal, w_ex_bal, w_ex_total;
    logic [BAL_W:0]   w_wd_sum, w_dep_sum;
    logic             w_ex_wr_bal, w_ex_wr_pin, w_ex_logout;

    assign w_timeout   = (r_state == c_S_MENU) && (r_timer == c_TIMEOUT);
    assign login_ready = (r_state == c_S_WAIT);
    assign op_ready    = (r_state == c_S_MENU) && !w_timeout;
    assign w_login_hs  = login_valid & login_ready;
    assign w_op_hs     = op_valid & op_ready;
    assign resp_valid  = (r_state == c_S_RESP);
    assign resp_code   = r_resp_code;
    assign balance     = r_balance;
    assign state       = r_state;

    assign w_login_acc_ok = ({1'b0, acc_num} < c_NUM_ACCTS);
    assign w_cfg_acc_ok   = ({1'b0, cfg_idx} < c_NUM_ACCTS);
    assign w_fail_inc     = r_snap_fails + 1'b1;
    assign w_cur_bal      = r_bal[r_acc];
    assign w_wd_sum       = {1'b0, r_total} + {1'b0, r_amt};
    assign w_dep_sum      = {1'b0, w_cur_bal} + {1'b0, r_amt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_S_WAIT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_WAIT: if (w_login_hs) w_state_nxt = c_S_AUTH;
            c_S_AUTH: w_state_nxt = c_S_RESP;
            c_S_MENU: begin
                if (w_timeout)    w_state_nxt = c_S_RESP;
                else if (w_op_hs) w_state_nxt = c_S_EXEC;
            end
            c_S_EXEC: w_state_nxt = c_S_RESP;
            c_S_RESP: w_state_nxt = r_to_menu ? c_S_MENU : c_S_WAIT;
            default:  w_state_nxt = c_S_WAIT;
        endcase
    end

    // Login verdict comes from account data snapshotted at the handshake edge.
    always_comb begin
        w_auth_code = c_R_OK;
        if (!r_acc_ok)         w_auth_code = c_R_NO_ACCT;
        else if (r_snap_lock)  w_auth_code = c_R_LOCKED;
        else if (!r_snap_match) w_auth_code = c_R_BAD_PIN;
    end

    always_comb begin
        w_ex_code   = c_R_OK;
        w_ex_bal    = w_cur_bal;
        w_ex_total  = r_total;
        w_ex_wr_bal = 1'b0;
        w_ex_wr_pin = 1'b0;
        w_ex_logout = 1'b0;
        case (r_op)
            c_OP_BAL: ;
            c_OP_WD: begin
                if (w_wd_sum > {1'b0, WD_LIMIT}) w_ex_code = c_R_LIMIT;
                else if (r_amt > w_cur_bal)      w_ex_code = c_R_INSUFF;
                else begin
                    w_ex_bal    = w_cur_bal - r_amt;
                    w_ex_total  = w_wd_sum[BAL_W-1:0];
                    w_ex_wr_bal = 1'b1;
                end
            end
            c_OP_DEP: begin
                if (w_dep_sum[BAL_W]) w_ex_code = c_R_OVF;
                else begin
                    w_ex_bal    = w_dep_sum[BAL_W-1:0];
                    w_ex_wr_bal = 1'b1;
                end
            end
            c_OP_CHGPIN: w_ex_wr_pin = 1'b1;
            c_OP_LOGOUT: w_ex_logout = 1'b1;
            default:     w_ex_code   = c_R_OVF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_bal[i]   <= INIT_BAL;
                r_pin[i]   <= INIT_PIN;
                r_fails[i] <= '0;
            end
            r_lock       <= '0;
            r_acc        <= '0;
            r_acc_ok     <= 1'b0;
            r_snap_match <= 1'b0;
            r_snap_lock  <= 1'b0;
            r_snap_fails <= '0;
            r_op         <= '0;
            r_amt        <= '0;
            r_new_pin    <= '0;
            r_total      <= '0;
            r_balance    <= '0;
            r_resp_code  <= '0;
            r_to_menu    <= 1'b0;
        end else begin
            case (r_state)
                c_S_WAIT: begin
                    if (w_login_hs) begin
                        r_acc        <= acc_num;
                        r_acc_ok     <= w_login_acc_ok;
                        r_snap_match <= w_login_acc_ok && (pin == r_pin[acc_num]);
                        r_snap_lock  <= w_login_acc_ok && r_lock[acc_num];
                        r_snap_fails <= w_login_acc_ok ? r_fails[acc_num] : '0;
                    end
                    if (cfg_we && w_cfg_acc_ok) begin
                        r_bal[cfg_idx]   <= cfg_bal;
                        r_pin[cfg_idx]   <= cfg_pin;
                        r_fails[cfg_idx] <= '0;
                        r_lock[cfg_idx]  <= 1'b0;
                    end
                end
                c_S_AUTH: begin
                    r_resp_code <= w_auth_code;
                    r_to_menu   <= 1'b0;
                    r_balance   <= '0;
                    case (w_auth_code)
                        c_R_OK: begin
                            r_fails[r_acc] <= '0;
                            r_total        <= '0;
                            r_to_menu      <= 1'b1;
                            r_balance      <= w_cur_bal;
                        end
                        c_R_BAD_PIN: begin
                            r_fails[r_acc] <= w_fail_inc;
                            if (w_fail_inc >= c_MAX_TRIES) r_lock[r_acc] <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_S_MENU: begin
                    if (w_timeout) begin
                        r_resp_code <= c_R_TIMEOUT;
                        r_to_menu   <= 1'b0;
                    end else if (w_op_hs) begin
                        r_op      <= op;
                        r_amt     <= amount;
                        r_new_pin <= new_pin;
                    end
                end
                c_S_EXEC: begin
                    if (w_ex_wr_bal) r_bal[r_acc] <= w_ex_bal;
                    if (w_ex_wr_pin) r_pin[r_acc] <= r_new_pin;
                    r_total     <= w_ex_total;
                    r_resp_code <= w_ex_code;
                    r_balance   <= w_ex_bal;
                    r_to_menu   <= !w_ex_logout;
                end
                c_S_RESP: begin
                    if (!r_to_menu) r_balance <= '0;
                end
                default: ;
            endcase
        end
    end

    // Idle timer saturates at the timeout value; leaving MENU or any accepted op clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_timer <= '0;
        else if (r_state != c_S_MENU || w_op_hs) r_timer <= '0;
        else if (!w_timeout)                     r_timer <= r_timer + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_atm_session_engine                                           |
// | Brief    : Randomised self-checking bench against a behavioural model.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_atm_session_engine;

    localparam int     NA  = 16;
    localparam int     TO  = 40;
    localparam int     MT  = 3;
    localparam longint WDL = 250;

    logic        clk, rst;
    logic        login_valid, login_ready, op_valid, op_ready, cfg_we, resp_valid;
    logic [3:0]  acc_num, cfg_idx;
    logic [15:0] pin, new_pin, cfg_pin;
    logic [2:0]  op, resp_code, state;
    logic [31:0] amount, cfg_bal, balance;

    atm_session_engine #(
        .NUM_ACCTS(NA), .BAL_W(32), .PIN_W(16), .MAX_TRIES(MT), .TIMEOUT_CYC(TO),
        .WD_LIMIT(32'd250), .INIT_BAL(32'd0), .INIT_PIN(16'h0000)
    ) dut (
        .clk(clk), .rst(rst),
        .login_valid(login_valid), .login_ready(login_ready),
        .acc_num(acc_num), .pin(pin),
        .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .amount(amount), .new_pin(new_pin),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_bal(cfg_bal), .cfg_pin(cfg_pin),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .balance(balance), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Account-level model: plain arrays and 64-bit arithmetic.
    logic [31:0] m_bal   [NA];
    logic [15:0] m_pin   [NA];
    int          m_fails [NA];
    bit          m_lock  [NA];
    longint      m_total;
    int          m_acc;
    bit          m_sess;
    int          n_checks, n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NA; i++) begin
            m_bal[i] = 32'd0; m_pin[i] = 16'h0000; m_fails[i] = 0; m_lock[i] = 1'b0;
        end
        m_total = 0; m_acc = 0; m_sess = 1'b0;
    endfunction

    function automatic void m_provision(input int a, input logic [31:0] b, input logic [15:0] p);
        m_bal[a] = b; m_pin[a] = p; m_fails[a] = 0; m_lock[a] = 1'b0;
    endfunction

    function automatic void m_login(input int a, input logic [15:0] p,
                                    output logic [2:0] code, output logic [31:0] bal);
        if (m_lock[a]) code = 3'd2;
        else if (p != m_pin[a]) begin
            code = 3'd1;
            m_fails[a]++;
            if (m_fails[a] >= MT) m_lock[a] = 1'b1;
        end else begin
            code = 3'd0; m_fails[a] = 0; m_total = 0; m_acc = a; m_sess = 1'b1;
        end
        bal = (code == 3'd0) ? m_bal[a] : 32'd0;
    endfunction

    function automatic void m_op(input logic [2:0] o, input logic [31:0] a, input logic [15:0] np,
                                 output logic [2:0] code, output logic [31:0] bal, output bit to_wait);
        longint la, lb;
        la = {32'd0, a};
        lb = {32'd0, m_bal[m_acc]};
        code = 3'd0; to_wait = 1'b0;
        case (o)
            3'd0: ;
            3'd1: begin
                if (m_total + la > WDL) code = 3'd6;
                else if (la > lb)       code = 3'd4;
                else begin m_bal[m_acc] = m_bal[m_acc] - a; m_total += la; end
            end
            3'd2: begin
                if (lb + la > 64'hFFFF_FFFF) code = 3'd5;
                else m_bal[m_acc] = m_bal[m_acc] + a;
            end
            3'd3: m_pin[m_acc] = np;
            3'd4: begin to_wait = 1'b1; m_sess = 1'b0; end
            default: code = 3'd5;
        endcase
        bal = m_bal[m_acc];
    endfunction

    task automatic provision(input logic [3:0] a, input logic [31:0] b, input logic [15:0] p);
        cfg_we = 1'b1; cfg_idx = a; cfg_bal = b; cfg_pin = p;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_provision(int'(a), b, p);
    endtask

    task automatic do_login(input logic [3:0] a, input logic [15:0] p, input bit with_cfg,
                            input logic [31:0] cb, input logic [15:0] cp);
        logic [2:0]  ec;
        logic [31:0] eb;
        m_login(int'(a), p, ec, eb);
        if (with_cfg) m_provision(int'(a), cb, cp);
        chk("login_ready", login_ready, 1);
        login_valid = 1'b1; acc_num = a; pin = p;
        cfg_we = with_cfg; cfg_idx = a; cfg_bal = cb; cfg_pin = cp;
        @(posedge clk); #1;
        login_valid = 1'b0; cfg_we = 1'b0;
        chk("login_auth_state", state, 3'd1);
        @(posedge clk); #1;
        chk("login_resp_valid", resp_valid, 1);
        chk("login_code", resp_code, ec);
        if (!with_cfg && ec == 3'd0) chk("login_bal", balance, eb);
        @(posedge clk); #1;
        chk("login_ret_state", state, (ec == 3'd0) ? 3'd2 : 3'd0);
        if (ec != 3'd0) chk("login_ret_bal", balance, 0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [15:0] np);
        logic [2:0]  ec;
        logic [31:0] eb;
        bit          tw;
        m_op(o, a, np, ec, eb, tw);
        chk("op_ready", op_ready, 1);
        op_valid = 1'b1; op = o; amount = a; new_pin = np;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("op_exec_state", state, 3'd3);
        @(posedge clk); #1;
        chk("op_resp_valid", resp_valid, 1);
        chk("op_code", resp_code, ec);
        chk("op_bal", balance, eb);
        @(posedge clk); #1;
        chk("op_ret_state", state, tw ? 3'd0 : 3'd2);
        if (tw) chk("op_ret_bal", balance, 0);
    endtask

    task automatic do_timeout();
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < TO + 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_seen", resp_valid, 1);
        chk("to_code", resp_code, 3'd7);
        chk("to_min_wait", 32'(n >= TO), 1);
        @(posedge clk); #1;
        chk("to_state", state, 3'd0);
        chk("to_bal", balance, 0);
        m_sess = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r, sel;
        logic [2:0]  o;
        logic [31:0] amt;
        logic [15:0] p;
        n_checks = 0; n_errors = 0;
        rst = 1'b0; login_valid = 1'b0; op_valid = 1'b0; cfg_we = 1'b0;
        acc_num = '0; pin = '0; op = '0; amount = '0; new_pin = '0;
        cfg_idx = '0; cfg_bal = '0; cfg_pin = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_login_ready", login_ready, 1);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_code", resp_code, 0);
        chk("rst_bal", balance, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Provision, login, withdraw, overflowing deposit, cap.
        provision(4'd2, 32'd500, 16'h1234);
        do_login(4'd2, 16'h1234, 1'b0, 0, 0);
        chk("spec_login_bal", balance, 32'd500);
        do_op(3'd1, 32'd200, 0);
        do_op(3'd2, 32'hFFFF_FFF0, 0);
        chk("spec_ovf_bal", balance, 32'd300);
        do_op(3'd1, 32'd100, 0);
        chk("spec_limit_code", resp_code, 3'd6);
        do_op(3'd4, 0, 0);

        // Insufficient funds, zero amount, bad op, PIN change.
        provision(4'd3, 32'd100, 16'h1111);
        do_login(4'd3, 16'h1111, 1'b0, 0, 0);
        do_op(3'd1, 32'd101, 0);
        chk("spec_insuff_code", resp_code, 3'd4);
        do_op(3'd1, 32'd0, 0);
        do_op(3'd6, 32'd5, 0);
        do_op(3'd3, 0, 16'h2222);
        do_op(3'd4, 0, 0);
        do_login(4'd3, 16'h1111, 1'b0, 0, 0);
        do_login(4'd3, 16'h2222, 1'b0, 0, 0);
        do_op(3'd4, 0, 0);

        // Lockout after three bad PINs, unlock by provisioning.
        for (int i = 0; i < MT; i++) do_login(4'd5, 16'h9999, 1'b0, 0, 0);
        do_login(4'd5, 16'h0000, 1'b0, 0, 0);
        chk("spec_locked_code", resp_code, 3'd2);
        provision(4'd5, 32'd50, 16'h0005);
        do_login(4'd5, 16'h0005, 1'b0, 0, 0);
        do_op(3'd4, 0, 0);

        // Idle timeout.
        do_login(4'd2, 16'h1234, 1'b0, 0, 0);
        do_timeout();

        // Login alongside a provisioning write to the same account uses the old PIN.
        do_login(4'd2, 16'h1234, 1'b1, 32'd777, 16'h5555);
        do_op(3'd0, 0, 0);
        do_op(3'd4, 0, 0);

        // Random sessions.
        for (int it = 0; it < 200; it++) begin
            sel = $urandom_range(0, 2);
            p = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h1234 : 16'h5555;
            if (m_sess) begin
                r = $urandom_range(0, 99);
                o = (r < 8) ? 3'd4 : 3'($urandom_range(0, 7));
                sel = $urandom_range(0, 9);
                if (sel == 0)      amt = 32'd0;
                else if (sel == 1) amt = $urandom();
                else if (sel == 2) amt = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                else               amt = 32'($urandom_range(1, 200));
                do_op(o, amt, p);
            end else if ($urandom_range(0, 3) == 0) begin
                provision(4'($urandom_range(0, 7)), 32'($urandom_range(0, 1000)), p);
            end else begin
                do_login(4'($urandom_range(0, 7)), p, 1'b0, 0, 0);
            end
        end
        if (m_sess) do_op(3'd4, 0, 0);

        // Reset during the commit cycle of a deposit wipes the store.
        provision(4'd2, 32'd300, 16'h1234);
        do_login(4'd2, 16'h1234, 1'b0, 0, 0);
        op_valid = 1'b1; op = 3'd2; amount = 32'd100;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("rstx_exec_state", state, 3'd3);
        rst = 1'b0;
        #2;
        chk("rstx_state", state, 0);
        chk("rstx_bal", balance, 0);
        chk("rstx_resp_valid", resp_valid, 0);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_login(4'd2, 16'h0000, 1'b0, 0, 0);
        chk("rstx_init_bal", balance, 32'd0);
        do_op(3'd4, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
